// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with single-cycle integer ops plus an iterative
// multiply/divide unit that owns the architectural HI/LO registers.
// Multiply is radix-2 shift-add and divide is restoring, one step per cycle.
// Optional feature: define ALU_MDU_DIV_EN to build DIV/DIVU support; without
// it the divider is not compiled and DIV/DIVU act as no-ops.
module alu_mdu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             valid,
   input  logic             flush,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       ALUOp,
   output logic [WIDTH-1:0] C,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Op codes shared with the control decoder
   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_ADDU  = 5'b00001;
   localparam logic [4:0] OP_SUB   = 5'b00010;
   localparam logic [4:0] OP_SUBU  = 5'b00011;
   localparam logic [4:0] OP_AND   = 5'b00100;
   localparam logic [4:0] OP_OR    = 5'b00101;
   localparam logic [4:0] OP_SLT   = 5'b00110;
   localparam logic [4:0] OP_SLL   = 5'b00111;
   localparam logic [4:0] OP_SRL   = 5'b01000;
   localparam logic [4:0] OP_SRA   = 5'b01001;
   localparam logic [4:0] OP_LUI   = 5'b01010;
   localparam logic [4:0] OP_EQL   = 5'b01011;
   localparam logic [4:0] OP_BNE   = 5'b01100;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
`ifdef ALU_MDU_DIV_EN
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
`endif
   localparam logic [4:0] OP_MFHI  = 5'b10100;
   localparam logic [4:0] OP_MFLO  = 5'b10101;
   localparam logic [4:0] OP_MTHI  = 5'b10110;
   localparam logic [4:0] OP_MTLO  = 5'b10111;

   localparam int CNTW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [CNTW-1:0]   cnt_reg;
   logic [WIDTH-1:0]  acc_reg;    // product upper half / partial remainder
   logic [WIDTH-1:0]  low_reg;    // multiplier -> product lower half / dividend -> quotient
   logic [WIDTH-1:0]  opnd_reg;   // multiplicand / divisor magnitude
   logic              neg_lo_reg; // negate product or quotient in FIX
   logic [WIDTH-1:0]  hi_reg, lo_reg;
   logic              done_reg, done_next;
   logic              hilo_wr;

   // ---------------- decode ----------------
   logic is_mul, is_div, is_mf, is_mt, md_op, op_signed, issue;

   assign is_mul = (ALUOp == OP_MULT) || (ALUOp == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
   assign is_div = (ALUOp == OP_DIV) || (ALUOp == OP_DIVU);
`else
   assign is_div = 1'b0;
`endif
   assign is_mf     = (ALUOp == OP_MFHI) || (ALUOp == OP_MFLO);
   assign is_mt     = (ALUOp == OP_MTHI) || (ALUOp == OP_MTLO);
   assign md_op     = is_mul || is_div;
   // Signed variants (MULT, DIV) have an even code
   assign op_signed = ~ALUOp[0];

   assign busy  = (state_reg != S_IDLE);
   assign issue = valid && !busy && !flush && md_op;
   assign stall = busy && valid && (md_op || is_mf || is_mt);
   assign done  = done_reg;
   assign hi    = hi_reg;
   assign lo    = lo_reg;

   // ---------------- operand preparation ----------------
   logic             a_neg, b_neg, neg_lo_load;
   logic [WIDTH-1:0] a_mag, b_mag, low_load;

   assign a_neg = op_signed & A[WIDTH-1];
   assign b_neg = op_signed & B[WIDTH-1];
   assign a_mag = a_neg ? -A : A;
   assign b_mag = b_neg ? -B : B;

`ifdef ALU_MDU_DIV_EN
   logic div_reg, neg_hi_reg, neg_hi_load;
`endif

   // Select what is loaded at issue; a zero divisor keeps the raw dividend so
   // the restoring loop naturally ends with quotient all ones, remainder = A
   always_comb begin
      low_load    = a_mag;
      neg_lo_load = a_neg ^ b_neg;
`ifdef ALU_MDU_DIV_EN
      neg_hi_load = 1'b0;
      if (is_div) begin
         if (B == '0) begin
            low_load    = A;
            neg_lo_load = 1'b0;
         end else begin
            neg_hi_load = a_neg;
         end
      end
`endif
   end

   // ---------------- iteration step ----------------
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] acc_iter, low_iter;

   assign mul_sum = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, opnd_reg} : '0);

`ifdef ALU_MDU_DIV_EN
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_sub;
   logic             div_ge;

   assign div_shift = {acc_reg, low_reg[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_reg};
   // Partial remainder stays below the divisor, so the difference fits WIDTH bits
   assign div_sub   = div_shift[WIDTH-1:0] - opnd_reg;
`endif

   // One shift-add (multiply) or shift-subtract (divide) step
   always_comb begin
      acc_iter = mul_sum[WIDTH:1];
      low_iter = {mul_sum[0], low_reg[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
      if (div_reg) begin
         acc_iter = div_ge ? div_sub : div_shift[WIDTH-1:0];
         low_iter = {low_reg[WIDTH-2:0], div_ge};
      end
`endif
   end

   // ---------------- sign fix-up ----------------
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   hi_fix, lo_fix;

   // Apply result signs to the magnitude result before it lands in HI/LO
   always_comb begin
      prod_fix = neg_lo_reg ? -{acc_reg, low_reg} : {acc_reg, low_reg};
      hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix   = prod_fix[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
      if (div_reg) begin
         lo_fix = neg_lo_reg ? -low_reg : low_reg;
         hi_fix = neg_hi_reg ? -acc_reg : acc_reg;
      end
`endif
   end

   // ---------------- control FSM ----------------
   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Next state, HI/LO write strobe and done request; flush overrides all
   always_comb begin
      state_next = state_reg;
      hilo_wr    = 1'b0;
      done_next  = 1'b0;
      case (state_reg)
         S_IDLE:  if (issue) state_next = S_CALC;
         S_CALC:  if (cnt_reg == CNTW'(WIDTH - 1)) state_next = S_FIX;
         S_FIX: begin
            state_next = S_IDLE;
            hilo_wr    = 1'b1;
            done_next  = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      if (flush) begin
         state_next = S_IDLE;
         hilo_wr    = 1'b0;
         done_next  = 1'b0;
      end
   end

   // Operand latch at issue and one iteration per CALC cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_reg    <= '0;
         acc_reg    <= '0;
         low_reg    <= '0;
         opnd_reg   <= '0;
         neg_lo_reg <= 1'b0;
`ifdef ALU_MDU_DIV_EN
         div_reg    <= 1'b0;
         neg_hi_reg <= 1'b0;
`endif
      end else if (issue) begin
         cnt_reg    <= '0;
         acc_reg    <= '0;
         low_reg    <= low_load;
         opnd_reg   <= b_mag;
         neg_lo_reg <= neg_lo_load;
`ifdef ALU_MDU_DIV_EN
         div_reg    <= is_div;
         neg_hi_reg <= neg_hi_load;
`endif
      end else if (state_reg == S_CALC) begin
         cnt_reg <= cnt_reg + CNTW'(1);
         acc_reg <= acc_iter;
         low_reg <= low_iter;
      end
   end

   // HI/LO architectural registers and the registered done pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi_reg   <= '0;
         lo_reg   <= '0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= done_next;
         if (hilo_wr) begin
            hi_reg <= hi_fix;
            lo_reg <= lo_fix;
         end else if (valid && !busy) begin
            if (ALUOp == OP_MTHI) hi_reg <= A;
            if (ALUOp == OP_MTLO) lo_reg <= A;
         end
      end
   end

   // ---------------- single-cycle ALU ----------------
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] and_res, or_res;

   assign shamt = A[SHW-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_logic
         assign and_res[gi] = A[gi] & B[gi];
         assign or_res[gi]  = A[gi] | B[gi];
      end
   endgenerate

   // Result mux; branch compares also expose A-B on C
   always_comb begin
      C = '0;
      case (ALUOp)
         OP_ADD, OP_ADDU:                 C = A + B;
         OP_SUB, OP_SUBU, OP_EQL, OP_BNE: C = A - B;
         OP_AND:                          C = and_res;
         OP_OR:                           C = or_res;
         OP_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL:  C = B << shamt;
         OP_SRL:  C = B >> shamt;
         OP_SRA:  C = $signed(B) >>> shamt;
         OP_LUI:  C = B << (WIDTH / 2);
         OP_MFHI: C = hi_reg;
         OP_MFLO: C = lo_reg;
         default: C = '0;
      endcase
   end

   // Zero flag: equality tests for branches, C==0 otherwise
   always_comb begin
      zero = (C == '0);
      case (ALUOp)
         OP_EQL:  zero = (A == B);
         OP_BNE:  zero = (A != B);
         default: zero = (C == '0);
      endcase
   end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized, scoreboard-checked bench for alu_mdu (WIDTH=32).
// Expected HI/LO results are queued at issue; a monitor thread pops and
// compares them whenever the DUT pulses done. Honors ALU_MDU_DIV_EN.
module tb_alu_mdu;

   localparam logic [4:0] OP_ADD   = 5'b00000;
   localparam logic [4:0] OP_ADDU  = 5'b00001;
   localparam logic [4:0] OP_SUB   = 5'b00010;
   localparam logic [4:0] OP_SUBU  = 5'b00011;
   localparam logic [4:0] OP_AND   = 5'b00100;
   localparam logic [4:0] OP_OR    = 5'b00101;
   localparam logic [4:0] OP_SLT   = 5'b00110;
   localparam logic [4:0] OP_SLL   = 5'b00111;
   localparam logic [4:0] OP_SRL   = 5'b01000;
   localparam logic [4:0] OP_SRA   = 5'b01001;
   localparam logic [4:0] OP_LUI   = 5'b01010;
   localparam logic [4:0] OP_EQL   = 5'b01011;
   localparam logic [4:0] OP_BNE   = 5'b01100;
   localparam logic [4:0] OP_MULT  = 5'b10000;
   localparam logic [4:0] OP_MULTU = 5'b10001;
   localparam logic [4:0] OP_DIV   = 5'b10010;
   localparam logic [4:0] OP_DIVU  = 5'b10011;
   localparam logic [4:0] OP_MFHI  = 5'b10100;
   localparam logic [4:0] OP_MFLO  = 5'b10101;
   localparam logic [4:0] OP_MTHI  = 5'b10110;
   localparam logic [4:0] OP_MTLO  = 5'b10111;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [4:0]  ALUOp = '0;
   logic [31:0] C, hi, lo;
   logic        zero, busy, done, stall;

   alu_mdu #(.WIDTH(32)) dut (
      .clk(clk), .rstn(rstn), .valid(valid), .flush(flush),
      .A(A), .B(B), .ALUOp(ALUOp),
      .C(C), .zero(zero), .busy(busy), .done(done), .stall(stall),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [4:0]  op;
   } exp_t;

   exp_t        exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] hi_m = '0;
   logic [31:0] lo_m = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference ALU: returns {zero, C}
   function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hv,
                                           input logic [31:0] lv);
      logic [31:0] c;
      logic        z;
      case (op)
         OP_ADD, OP_ADDU:                 c = a + b;
         OP_SUB, OP_SUBU, OP_EQL, OP_BNE: c = a - b;
         OP_AND:  c = a & b;
         OP_OR:   c = a | b;
         OP_SLT:  c = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         OP_SLL:  c = b << a[4:0];
         OP_SRL:  c = b >> a[4:0];
         OP_SRA:  c = 32'(int'(b) >>> a[4:0]);
         OP_LUI:  c = {b[15:0], 16'h0000};
         OP_MFHI: c = hv;
         OP_MFLO: c = lv;
         default: c = 32'd0;
      endcase
      if (op == OP_EQL)      z = (a == b);
      else if (op == OP_BNE) z = (a != b);
      else                   z = (c == 32'd0);
      return {z, c};
   endfunction

   // Reference multiply/divide in 64-bit arithmetic: returns {HI, LO}
   function automatic logic [63:0] ref_md(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      sa = int'(a);
      sb = int'(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return $urandom;
         1:       return 32'd0;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(1, 20));
         default: return -32'($urandom_range(1, 20));
      endcase
   endfunction

   // Scoreboard monitor: compare HI/LO on every done pulse
   task automatic monitor_proc();
      logic prev_done = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rstn && done) begin
            check("done_not_twice", {63'd0, prev_done}, 64'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, expected no result pending");
            end else begin
               e = exp_q.pop_front();
               $display("[TB] done op=%b hi=%h lo=%h", e.op, hi, lo);
               check("md_hi", {32'd0, hi}, {32'd0, e.hi});
               check("md_lo", {32'd0, lo}, {32'd0, e.lo});
            end
         end
         prev_done = rstn ? done : 1'b0;
      end
   endtask

   task automatic alu_check(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] r;
      valid = 1'b1; ALUOp = op; A = a; B = b;
      #1;
      r = ref_alu(op, a, b, hi_m, lo_m);
      $display("[TB] alu op=%b a=%h b=%h c=%h z=%b", op, a, b, C, zero);
      check("alu_c", {32'd0, C}, {32'd0, r[31:0]});
      check("alu_zero", {63'd0, zero}, {63'd0, r[32]});
      step();
      valid = 1'b0;
   endtask

   // Present a multiply/divide op in the current cycle; returns in cycle 1
   task automatic md_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit expect_res);
      logic [63:0] r;
      exp_t        e;
      valid = 1'b1; ALUOp = op; A = a; B = b;
      if (expect_res) begin
         r = ref_md(op, a, b);
         e.hi = r[63:32]; e.lo = r[31:0]; e.op = op;
         exp_q.push_back(e);
         hi_m = r[63:32];
         lo_m = r[31:0];
      end
      step();
      valid = 1'b0; A = $urandom; B = $urandom;
   endtask

   // From cycle 1, wait for done (bounded) and check latency; ends in the done cycle
   task automatic md_wait_check(input string name);
      int lat = 0;
      int bc  = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (busy) bc++;
         if (done) begin
            lat = cyc;
            break;
         end
         step();
      end
      check({name, "_latency"}, 64'(lat), 64'd34);
      check({name, "_busy_cycles"}, 64'(bc), 64'd33);
   endtask

   logic [4:0] rnd_ops [16] = '{OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_SLL,
                                OP_SRL, OP_SRA, OP_LUI, OP_EQL, OP_BNE, OP_MFHI, OP_MFLO, 5'b11101};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          sc;
      int          bc;
      logic [4:0]  op;
      logic [31:0] a, b;

      fork
         monitor_proc();
      join_none

      // Reset state
      #2;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      repeat (2) step();
      rstn = 1'b1;
      step();

      // Directed single-cycle cases
      alu_check(OP_ADDU, 32'd7, 32'd5);
      alu_check(OP_SUB, 32'd5, 32'd5);
      alu_check(OP_SRA, 32'd4, 32'h8000_0000);
      alu_check(OP_SLT, 32'hFFFF_FFFF, 32'd1);
      alu_check(OP_BNE, 32'd3, 32'd3);
      alu_check(OP_EQL, 32'd3, 32'd3);
      alu_check(OP_LUI, 32'd0, 32'h0000_ABCD);

      // Random single-cycle ops
      for (int i = 0; i < 30; i++)
         alu_check(rnd_ops[$urandom_range(0, 15)], $urandom, $urandom);

      // Directed multiplies with latency check
      md_issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1);
      md_wait_check("mult");
      md_issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
      md_wait_check("multu");

`ifdef ALU_MDU_DIV_EN
      md_issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);
      md_wait_check("div");
      md_issue(OP_DIVU, 32'h8000_0000, 32'd0, 1);
      md_wait_check("divu_zero");
      md_issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
      md_wait_check("div_ovf");
      step();
`else
      // Divider absent: DIV/DIVU must do nothing
      for (int k = 0; k < 2; k++) begin
         valid = 1'b1; ALUOp = (k == 0) ? OP_DIV : OP_DIVU; A = $urandom; B = 32'd3;
         #1;
         check("div_off_c", {32'd0, C}, 64'd0);
         step();
         valid = 1'b0;
         bc = 0;
         repeat (40) begin
            if (busy) bc++;
            step();
         end
         check("div_off_busy", 64'(bc), 64'd0);
         check("div_off_hi", {32'd0, hi}, {32'd0, hi_m});
         check("div_off_lo", {32'd0, lo}, {32'd0, lo_m});
      end
`endif

      // MFLO during a MULT stalls until the done cycle; a second MULT is ignored
      md_issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1);
      repeat (4) step();
      valid = 1'b1;
      sc = 0;
      for (int cyc = 5; cyc <= 33; cyc++) begin
         if (cyc == 10) begin
            ALUOp = OP_MULT; A = 32'd9; B = 32'd9;
         end else begin
            ALUOp = OP_MFLO;
         end
         #1;
         if (stall) sc++;
         step();
      end
      #1;
      check("mf_stall_cycles", 64'(sc), 64'd29);
      check("mf_stall_released", {63'd0, stall}, 64'd0);
      check("mf_done_cycle", {63'd0, done}, 64'd1);
      check("mf_new_lo", {32'd0, C}, {32'd0, lo_m});
      step();
      valid = 1'b0;

      // Random multiply/divide, back-to-back, MF read in the done cycle
      for (int i = 0; i < 16; i++) begin
`ifdef ALU_MDU_DIV_EN
         case ($urandom_range(0, 3))
            0:       op = OP_MULT;
            1:       op = OP_MULTU;
            2:       op = OP_DIV;
            default: op = OP_DIVU;
         endcase
`else
         op = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
`endif
         a = pick_operand();
         b = pick_operand();
         md_issue(op, a, b, 1);
         md_wait_check("rand_md");
         if (i % 2 == 0) begin
            valid = 1'b1; ALUOp = (i % 4 == 0) ? OP_MFHI : OP_MFLO;
            #1;
            check("mf_in_done", {32'd0, C}, {32'd0, (i % 4 == 0) ? hi_m : lo_m});
         end
      end
      step();
      valid = 1'b0;
      repeat (40) step();

      // Flush mid-operation after MTHI
      valid = 1'b1; ALUOp = OP_MTHI; A = 32'h0000_1234;
      step();
      valid = 1'b0;
      hi_m = 32'h0000_1234;
      check("mthi", {32'd0, hi}, {32'd0, hi_m});
`ifdef ALU_MDU_DIV_EN
      md_issue(OP_DIV, $urandom, 32'd3, 0);
`else
      md_issue(OP_MULT, $urandom, 32'd3, 0);
`endif
      repeat (11) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      repeat (40) step();
      check("flush_hi", {32'd0, hi}, {32'd0, hi_m});
      check("flush_lo", {32'd0, lo}, {32'd0, lo_m});

      // Asynchronous reset in the middle of a MULT
      md_issue(OP_MULT, 32'h1234_5678, 32'h0000_0100, 1);
      repeat (14) step();
      #2;
      rstn = 1'b0;
      #1;
      check("arst_busy", {63'd0, busy}, 64'd0);
      check("arst_done", {63'd0, done}, 64'd0);
      check("arst_hi", {32'd0, hi}, 64'd0);
      check("arst_lo", {32'd0, lo}, 64'd0);
      exp_q.delete();
      hi_m = '0;
      lo_m = '0;
      step();
      rstn = 1'b1;
      step();

      // Unit works again after reset
      md_issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1);
      md_wait_check("post_rst");
      step();
      repeat (5) step();

      check("pending_results", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
